// File: rtl/freq_disp_pkg.sv
// Shared definitions for the frequency display formatter: unit codes, the blank
// digit code, range tests on the BCD result and the formatter FSM encoding.
package freq_disp_pkg;

  typedef enum logic [1:0] {
    UNIT_HZ  = 2'd0,
    UNIT_KHZ = 2'd1,
    UNIT_MHZ = 2'd2
  } unit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RANGE = 2'd2
  } fmt_state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam int         BCD_W     = 32;

  localparam logic [2:0] DP_HZ  = 3'd0;
  localparam logic [2:0] DP_KHZ = 3'd3;
  localparam logic [2:0] DP_MHZ = 3'd4;

  // v >= 1,000,000 exactly when either of the top two digits is non-zero
  function automatic logic is_mhz(input logic [BCD_W-1:0] bcd);
    return bcd[31:24] != 8'd0;
  endfunction

  // v >= 1,000 (given v < 1,000,000) exactly when d5..d3 is non-zero
  function automatic logic is_khz(input logic [BCD_W-1:0] bcd);
    return bcd[23:12] != 12'd0;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one bit per clock. done is high during the final
// shift cycle, so bcd holds the finished result from the following cycle on.
module bin2bcd_seq #(
  parameter int BIN_W  = 26,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int              CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  logic [BIN_W-1:0]    shift_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic                busy_reg;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
  end

  assign done = busy_reg && (bit_cnt_reg == LAST_BIT);
  assign busy = busy_reg;
  assign bcd  = bcd_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      bcd_reg     <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
    end else if (start && !busy_reg) begin
      shift_reg   <= bin;
      bcd_reg     <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b1;
    end else if (busy_reg) begin
      {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
      bit_cnt_reg          <= bit_cnt_reg + CNT_W'(1);
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_bcd_format.sv
// Converts the measured Hz value to BCD, auto-ranges to Hz/kHz/MHz and presents a
// 6-digit display word. Define FREQ_BCD_LZ_BLANK_EN to blank leading zeros.
module freq_bcd_format
  import freq_disp_pkg::*;
#(
  parameter int FREQ_W      = 26,
  parameter int BCD_DIGITS  = 8,
  parameter int DISP_DIGITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FREQ_W-1:0]        freq_in,
  input  logic                     f_update,
  output logic [4*DISP_DIGITS-1:0] disp_bcd,
  output logic [2:0]               dp_pos,
  output logic [1:0]               unit,
  output logic                     disp_valid,
  output logic                     busy
);

  logic f_sync1_reg, f_sync2_reg, f_sync3_reg;
  logic rise;

  fmt_state_t                 state_reg;
  logic                       pending_reg;
  logic [4*DISP_DIGITS-1:0]   disp_bcd_reg;
  logic [2:0]                 dp_pos_reg;
  unit_t                      unit_reg;
  logic                       disp_valid_reg;
  logic                       busy_reg;

  logic                       conv_start;
  logic                       conv_busy;
  logic                       conv_done;
  logic [4*BCD_DIGITS-1:0]    conv_bcd;

  unit_t                      range_unit;
  logic [2:0]                 range_dp;
  logic [4*DISP_DIGITS-1:0]   range_digits;
  logic [4*DISP_DIGITS-1:0]   disp_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_sync1_reg <= 1'b0;
      f_sync2_reg <= 1'b0;
      f_sync3_reg <= 1'b0;
    end else begin
      f_sync1_reg <= f_update;
      f_sync2_reg <= f_sync1_reg;
      f_sync3_reg <= f_sync2_reg;
    end
  end

  assign rise       = f_sync2_reg & ~f_sync3_reg;
  assign conv_start = (state_reg == ST_IDLE) && (rise || pending_reg) && !conv_busy;

  bin2bcd_seq #(
    .BIN_W  (FREQ_W),
    .DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (freq_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    range_unit   = UNIT_HZ;
    range_dp     = DP_HZ;
    range_digits = conv_bcd[23:0];
    if (is_mhz(conv_bcd)) begin
      range_unit   = UNIT_MHZ;
      range_dp     = DP_MHZ;
      range_digits = conv_bcd[31:8];
    end else if (is_khz(conv_bcd)) begin
      range_unit = UNIT_KHZ;
      range_dp   = DP_KHZ;
    end
  end

`ifdef FREQ_BCD_LZ_BLANK_EN
  // zero_run[i]: digits DISP_DIGITS-1 down to i are all zero
  logic [DISP_DIGITS:0] zero_run;
  assign zero_run[DISP_DIGITS] = 1'b1;
  for (genvar gi = DISP_DIGITS - 1; gi >= 0; gi--) begin : g_blank
    assign zero_run[gi] = zero_run[gi+1] && (range_digits[4*gi +: 4] == 4'd0);
    assign disp_word[4*gi +: 4] = (zero_run[gi] && (3'(gi) > range_dp)) ?
                                  BCD_BLANK : range_digits[4*gi +: 4];
  end
`else
  assign disp_word = range_digits;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pending_reg    <= 1'b0;
      disp_bcd_reg   <= '0;
      dp_pos_reg     <= 3'd0;
      unit_reg       <= UNIT_HZ;
      disp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      disp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (conv_start) begin
            pending_reg <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise) pending_reg <= 1'b1;
          if (conv_done) state_reg <= ST_RANGE;
        end
        ST_RANGE: begin
          if (rise) pending_reg <= 1'b1;
          disp_bcd_reg   <= disp_word;
          dp_pos_reg     <= range_dp;
          unit_reg       <= range_unit;
          disp_valid_reg <= 1'b1;
          busy_reg       <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign disp_bcd   = disp_bcd_reg;
  assign dp_pos     = dp_pos_reg;
  assign unit       = unit_reg;
  assign disp_valid = disp_valid_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_freq_bcd_format.sv
// Directed and random checks of freq_bcd_format against a decimal-arithmetic model.
module tb_freq_bcd_format;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] freq_in;
  logic        f_update;
  logic [23:0] disp_bcd;
  logic [2:0]  dp_pos;
  logic [1:0]  unit;
  logic        disp_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc;
  int          pv_cyc[$];
  logic [23:0] pv_word[$];
  logic [1:0]  pv_unit[$];
  logic [2:0]  pv_dp[$];

  freq_bcd_format dut (
    .clk        (clk),
    .rst        (rst),
    .freq_in    (freq_in),
    .f_update   (f_update),
    .disp_bcd   (disp_bcd),
    .dp_pos     (dp_pos),
    .unit       (unit),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scale by decimal range, then write six decimal digits.
  function automatic void model(input int unsigned v, output logic [23:0] w,
                                output logic [1:0] u, output logic [2:0] dp);
    int unsigned s, t, ip, pw;
    int n;
    if (v >= 1000000) begin u = 2; dp = 4; s = v / 100; end
    else if (v >= 1000) begin u = 1; dp = 3; s = v; end
    else begin u = 0; dp = 0; s = v; end
    w = '0;
    t = s;
    for (int i = 0; i < 6; i++) begin
      w[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef FREQ_BCD_LZ_BLANK_EN
    pw = 1;
    for (int i = 0; i < int'(dp); i++) pw = pw * 10;
    ip = s / pw;
    n  = 1;
    while (ip >= 10) begin ip = ip / 10; n++; end
    for (int i = int'(dp) + n; i < 6; i++) w[4*i +: 4] = 4'hF;
`else
    pw = 0; ip = 0; n = 0;
`endif
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (disp_valid) begin
        pv_cyc.push_back(cyc);
        pv_word.push_back(disp_bcd);
        pv_unit.push_back(unit);
        pv_dp.push_back(dp_pos);
      end
    end
  endtask

  task automatic clear_log();
    cyc = 0;
    pv_cyc.delete(); pv_word.delete(); pv_unit.delete(); pv_dp.delete();
  endtask

  task automatic convert(input int unsigned v);
    logic [23:0] ew;
    logic [1:0]  eu;
    logic [2:0]  ed;
    int n;
    model(v, ew, eu, ed);
    freq_in  = 26'(v);
    f_update = 1'b1;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) chk("busy_mid", 32'(busy), 32'd1);
      if (disp_valid) break;
    end
    chk("latency", n, 30);
    chk("word", 32'(disp_bcd), 32'(ew));
    chk("unit", 32'(unit), 32'(eu));
    chk("dp", 32'(dp_pos), 32'(ed));
    chk("busy_done", 32'(busy), 32'd0);
    $display("conv freq=%0d word=%06h unit=%0d dp=%0d latency=%0d", v, disp_bcd, unit, dp_pos, n);
    @(posedge clk); #1;
    chk("strobe_1cyc", 32'(disp_valid), 32'd0);
    chk("hold_word", 32'(disp_bcd), 32'(ew));
    f_update = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] ew;
    logic [1:0]  eu;
    logic [2:0]  ed;
    int unsigned dir[11] = '{50, 123456, 999, 1000, 12345678, 67108863, 0,
                             1234567, 7, 999999, 1000000};
    rst = 1'b1; f_update = 1'b0; freq_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", 32'(disp_bcd), 32'd0);
    chk("rst_dp", 32'(dp_pos), 32'd0);
    chk("rst_unit", 32'(unit), 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (dir[i]) convert(dir[i]);
    for (int i = 0; i < 6; i++) begin
      convert($urandom_range(0, 999));
      convert($urandom_range(1000, 999999));
      convert($urandom_range(1000000, 67108863));
    end

    // Second rise 10 cycles after the first: queued, 28 cycles apart
    clear_log();
    freq_in = 26'd500; f_update = 1'b1;
    step(5);  f_update = 1'b0;
    step(5);  freq_in = 26'd2000; f_update = 1'b1;
    step(70); f_update = 1'b0;
    step(4);
    chk("pend_count", pv_cyc.size(), 2);
    chk("pend_first_cyc", pv_cyc[0], 30);
    chk("pend_gap", pv_cyc[1] - pv_cyc[0], 28);
    model(500, ew, eu, ed);
    chk("pend_word0", 32'(pv_word[0]), 32'(ew));
    chk("pend_unit0", 32'(pv_unit[0]), 32'(eu));
    model(2000, ew, eu, ed);
    chk("pend_word1", 32'(pv_word[1]), 32'(ew));
    chk("pend_unit1", 32'(pv_unit[1]), 32'(eu));
    chk("pend_dp1", 32'(pv_dp[1]), 32'(ed));

    // Several rises in one conversion collapse; the latest freq_in wins
    clear_log();
    freq_in = 26'd700; f_update = 1'b1;
    step(4);  f_update = 1'b0;
    step(4);  freq_in = 26'd800; f_update = 1'b1;
    step(4);  f_update = 1'b0;
    step(4);  freq_in = 26'd3000; f_update = 1'b1;
    step(4);  f_update = 1'b0;
    step(80);
    chk("collapse_count", pv_cyc.size(), 2);
    model(3000, ew, eu, ed);
    chk("collapse_word", 32'(pv_word[1]), 32'(ew));
    chk("collapse_unit", 32'(pv_unit[1]), 32'(eu));

    // Level held high converts once
    clear_log();
    freq_in = 26'd4321; f_update = 1'b1;
    step(100);
    chk("held_count", pv_cyc.size(), 1);
    f_update = 1'b0;
    step(4);

    // Reset 12 cycles into a conversion
    clear_log();
    freq_in = 26'd456; f_update = 1'b1;
    step(15);
    rst = 1'b1; f_update = 1'b0;
    #1;
    chk("mid_rst_word", 32'(disp_bcd), 32'd0);
    chk("mid_rst_unit", 32'(unit), 32'd0);
    chk("mid_rst_dp", 32'(dp_pos), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step(2);
    rst = 1'b0;
    step(40);
    chk("mid_rst_nopulse", pv_cyc.size(), 0);
    convert(8765);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
